// File: rtl/exec_unit.sv
// exec_unit
//   Single-issue functional unit fed by a reservation-station queue.
//   Executes either a one-cycle negate or a 32-step shift-and-add square.
//   The result is then held, and the common data bus is requested until an
//   arbiter grants the broadcast.
//
// Ports
//   clk        in   1   clock; all state changes on the rising edge
//   RST        in   1   synchronous active-high reset
//   require    in   1   queue head is valid and ready to issue
//   opIn       in   1   0 = negate, 1 = square
//   dataIn     in  32   operand, sampled on the accept edge only
//   labelIn    in   4   ID label, returned with the result
//   requireAC  out  1   unit can accept this cycle (combinational from BCgrant)
//   BCreq      out  1   held result valid, requesting the CDB
//   BClabel    out  4   label of the held result
//   BCdata     out 32   held result value
//   BCgrant    in   1   CDB grant; consumes the result when BCreq is high
//   busy       out  1   unit is not idle
module exec_unit (
  input  logic        clk,
  input  logic        RST,
  input  logic        require,
  input  logic        opIn,
  input  logic [31:0] dataIn,
  input  logic [3:0]  labelIn,
  output logic        requireAC,
  output logic        BCreq,
  output logic [3:0]  BClabel,
  output logic [31:0] BCdata,
  input  logic        BCgrant,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] m_reg, m_next;       // multiplicand, shifted left each step
  logic [31:0] q_reg, q_next;       // multiplier, shifted right each step
  logic [31:0] p_reg, p_next;       // partial product
  logic [4:0]  cnt_reg, cnt_next;   // step counter, 0..31
  logic [3:0]  label_reg, label_next;
  logic [31:0] data_reg, data_next;

  logic        acc;
  logic [31:0] p_step;

  // Accepting is also allowed in DONE when the held result is being granted
  // at this very edge, so a new op can load without an idle bubble.
  assign requireAC = (state_reg == IDLE) || ((state_reg == DONE) && BCgrant);
  assign acc       = require && requireAC;
  assign BCreq     = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign BClabel   = label_reg;
  assign BCdata    = data_reg;

  assign p_step    = q_reg[0] ? (p_reg + m_reg) : p_reg;

  always_comb begin
    state_next = state_reg;
    m_next     = m_reg;
    q_next     = q_reg;
    p_next     = p_reg;
    cnt_next   = cnt_reg;
    label_next = label_reg;
    data_next  = data_reg;

    case (state_reg)
      MUL: begin
        p_next   = p_step;
        m_next   = m_reg << 1;
        q_next   = q_reg >> 1;
        cnt_next = cnt_reg + 5'd1;
        // Last step: the final partial product becomes the result.
        if (cnt_reg == 5'd31) begin
          data_next  = p_step;
          state_next = DONE;
        end
      end
      DONE: begin
        if (BCgrant) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = state_reg;
      end
    endcase

    // A new op overrides whatever IDLE/DONE decided above; acc can only be
    // true in IDLE or in a granted DONE.
    if (acc) begin
      label_next = labelIn;
      if (!opIn) begin
        data_next  = 32'd0 - dataIn;
        state_next = DONE;
      end else begin
        m_next     = dataIn;
        q_next     = dataIn;
        p_next     = 32'd0;
        cnt_next   = 5'd0;
        state_next = MUL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg <= IDLE;
      m_reg     <= 32'd0;
      q_reg     <= 32'd0;
      p_reg     <= 32'd0;
      cnt_reg   <= 5'd0;
      label_reg <= 4'd0;
      data_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      m_reg     <= m_next;
      q_reg     <= q_next;
      p_reg     <= p_next;
      cnt_reg   <= cnt_next;
      label_reg <= label_next;
      data_reg  <= data_next;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit
//   Randomized and directed stimulus for exec_unit. A driver keeps an
//   abstract occupancy model (in flight / cycle the result becomes visible)
//   and pushes expected results into a scoreboard queue on every accept;
//   a monitor compares the DUT broadcast against the queue front.
module tb_exec_unit;

  logic        clk;
  logic        RST;
  logic        require;
  logic        opIn;
  logic [31:0] dataIn;
  logic [3:0]  labelIn;
  logic        requireAC;
  logic        BCreq;
  logic [3:0]  BClabel;
  logic [31:0] BCdata;
  logic        BCgrant;
  logic        busy;

  exec_unit dut (
    .clk       (clk),
    .RST       (RST),
    .require   (require),
    .opIn      (opIn),
    .dataIn    (dataIn),
    .labelIn   (labelIn),
    .requireAC (requireAC),
    .BCreq     (BCreq),
    .BClabel   (BClabel),
    .BCdata    (BCdata),
    .BCgrant   (BCgrant),
    .busy      (busy)
  );

  typedef struct {
    logic [3:0]  label;
    logic [31:0] data;
    int          ready;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // abstract model of unit occupancy
  bit in_flight = 0;
  int ready_cyc = 0;

  // monitor bookkeeping
  bit prev_req      = 0;
  bit prev_consumed = 0;
  int first_seen    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input bit ok, input string name,
                                input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, req);
  endfunction

  // Driver-side model step, evaluated mid-cycle once inputs are stable.
  task automatic model_eval();
    bit   exp_req, exp_ac;
    exp_t e;
    exp_req = in_flight && (cyc >= ready_cyc);
    exp_ac  = !in_flight || (exp_req && BCgrant);
    check(requireAC === exp_ac, "requireAC", {31'd0, requireAC}, {31'd0, exp_ac});
    check(BCreq === exp_req, "BCreq", {31'd0, BCreq}, {31'd0, exp_req});
    check(busy === in_flight, "busy", {31'd0, busy}, {31'd0, in_flight});
    if (RST) begin
      in_flight = 0;
      sb.delete();
    end else if (require && exp_ac) begin
      e.label = labelIn;
      if (!opIn) begin
        e.data  = 32'd0 - dataIn;
        e.ready = cyc + 1;
      end else begin
        e.data  = dataIn * dataIn;
        e.ready = cyc + 33;
      end
      sb.push_back(e);
      in_flight = 1;
      ready_cyc = e.ready;
    end else if (exp_req && BCgrant) begin
      in_flight = 0;
    end
  endtask

  task automatic step(input logic r, input logic rq, input logic op,
                      input logic [31:0] d, input logic [3:0] l, input logic g);
    @(posedge clk);
    #1;
    RST     = r;
    require = rq;
    opIn    = op;
    dataIn  = d;
    labelIn = l;
    BCgrant = g;
    @(negedge clk);
    model_eval();
  endtask

  // Monitor: whenever a result is on the bus it must match the queue front;
  // on consumption the entry is popped and its first-visible cycle checked.
  always @(negedge clk) begin
    if (!RST) begin
      if (BCreq && (!prev_req || prev_consumed)) first_seen = cyc;
      if (BCreq) begin
        if (sb.size() == 0) begin
          check(1'b0, "spurious_result", BCdata, 32'd0);
        end else begin
          check(BCdata === sb[0].data, "BCdata", BCdata, sb[0].data);
          check(BClabel === sb[0].label, "BClabel", {28'd0, BClabel}, {28'd0, sb[0].label});
          if (BCgrant) begin
            check(first_seen == sb[0].ready, "latency", first_seen, sb[0].ready);
            $display("result label=%h data=%h visible_at=%0d consumed_at=%0d",
                     BClabel, BCdata, first_seen, cyc);
            void'(sb.pop_front());
          end
        end
      end
    end
    prev_req      = BCreq;
    prev_consumed = BCreq && BCgrant && !RST;
  end

  initial begin
    RST = 1'b1; require = 1'b0; opIn = 1'b0; dataIn = 32'd0;
    labelIn = 4'd0; BCgrant = 1'b0;

    // reset and reset values
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 32'hDEAD_BEEF, 4'hF, 0);
    check(BCdata === 32'd0, "reset_BCdata", BCdata, 32'd0);
    check(BClabel === 4'd0, "reset_BClabel", {28'd0, BClabel}, 32'd0);
    $display("reset done");

    // negate 5, label 3
    step(0, 1, 0, 32'd5, 4'h3, 0);
    step(0, 0, 0, 32'd0, 4'h0, 0);
    check(BCdata === 32'hFFFF_FFFB, "neg5_data", BCdata, 32'hFFFF_FFFB);
    step(0, 0, 0, 32'd0, 4'h0, 1);
    step(0, 0, 0, 32'd0, 4'h0, 0);

    // squares with grant held
    step(0, 1, 1, 32'd7, 4'h2, 1);
    for (int i = 0; i < 34; i++) step(0, (i % 3) == 0, 1, $urandom, 4'hA, 1);
    step(0, 1, 1, 32'h0001_0000, 4'h8, 1);
    for (int i = 0; i < 34; i++) step(0, 0, 0, $urandom, 4'h0, 1);
    step(0, 1, 1, 32'hFFFF_FFFF, 4'h9, 1);
    for (int i = 0; i < 34; i++) step(0, 0, 0, 32'd0, 4'h0, 1);

    // grant stall: negate 1 held for 10 cycles
    step(0, 1, 0, 32'd1, 4'h5, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 1, $urandom, 4'hC, 0);
    step(0, 0, 0, 32'd0, 4'h0, 1);
    step(0, 0, 0, 32'd0, 4'h0, 0);

    // back-to-back negates
    for (int i = 1; i <= 4; i++) step(0, 1, 0, i, i[3:0], 1);
    step(0, 0, 0, 32'd0, 4'h0, 1);
    step(0, 0, 0, 32'd0, 4'h0, 0);

    // reset mid-square
    step(0, 1, 1, 32'd9, 4'h6, 1);
    for (int i = 0; i < 14; i++) step(0, 0, 0, $urandom, 4'h0, 1);
    step(1, 1, 0, 32'd3, 4'h1, 1);
    step(0, 1, 0, 32'd2, 4'h7, 0);
    step(0, 0, 0, 32'd0, 4'h0, 0);
    check(BCdata === 32'hFFFF_FFFE, "neg2_after_rst", BCdata, 32'hFFFF_FFFE);
    step(0, 0, 0, 32'd0, 4'h0, 1);

    // ignored inputs while idle
    for (int i = 0; i < 5; i++) step(0, 0, $urandom_range(0, 1), $urandom, 4'(i), 1);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), $urandom, 4'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    // drain
    for (int i = 0; i < 40; i++) step(0, 0, 0, 32'd0, 4'h0, 1);
    check(sb.size() == 0, "drain_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
